// File: rtl/pipelined_adder_wrapper_if.sv
// Valid/ready bundle for pipelined_adder_wrapper.
// out_ovf is present only when OVERFLOW_FLAG_EN is defined.
interface pipelined_adder_wrapper_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
`ifdef OVERFLOW_FLAG_EN
   logic             out_ovf;

   modport master (
      output in_valid, in_a, in_b,
      output in_cin, in_sub, out_ready,
      input  in_ready, out_valid,
      input  out_sum, out_cout, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b,
      input  in_cin, in_sub, out_ready,
      output in_ready, out_valid,
      output out_sum, out_cout, out_ovf
   );
`else
   modport master (
      output in_valid, in_a, in_b,
      output in_cin, in_sub, out_ready,
      input  in_ready, out_valid,
      input  out_sum, out_cout
   );

   modport slave (
      input  in_valid, in_a, in_b,
      input  in_cin, in_sub, out_ready,
      output in_ready, out_valid,
      output out_sum, out_cout
   );
`endif
endinterface

// File: rtl/pipelined_adder_wrapper.sv
// Segmented pipelined add/sub, SEG bits per stage, global stall.
// Optional signed-overflow flag: define OVERFLOW_FLAG_EN.
module pipelined_adder_wrapper #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input logic                    clk,
   input logic                    rst,
   pipelined_adder_wrapper_if.slave io_bus
);
   localparam int NSEG = WIDTH / SEG;

   logic             w_adv;
   logic             w_out_valid;
   logic [WIDTH-1:0] w_bx;
   logic             w_seed;

   if ((WIDTH % SEG) != 0 || WIDTH < SEG) begin : g_bad
      $error("WIDTH must be a nonzero multiple of SEG");
   end

   assign w_out_valid     = g_stg[NSEG-1].r_v;
   assign w_adv           = io_bus.out_ready
                          || !w_out_valid;
   assign io_bus.in_ready = w_adv;

   // subtract as A + ~B + 1; cin is ignored then
   assign w_bx   = io_bus.in_sub ? ~io_bus.in_b
                                 : io_bus.in_b;
   assign w_seed = io_bus.in_sub | io_bus.in_cin;

   for (genvar k = 0; k < NSEG; k++) begin : g_stg
      localparam int SW = (k + 1) * SEG;
      localparam int RW = WIDTH - SW;

      logic [SEG-1:0] w_a;
      logic [SEG-1:0] w_b;
      logic           w_ci;
      logic           w_vi;
      logic [SEG:0]   w_add;
      logic [SW-1:0]  w_sum;
      logic [SW-1:0]  r_sum;
      logic           r_c;
      logic           r_v;

      if (k == 0) begin : g_src
         assign w_a   = io_bus.in_a[SEG-1:0];
         assign w_b   = w_bx[SEG-1:0];
         assign w_ci  = w_seed;
         assign w_vi  = io_bus.in_valid;
         assign w_sum = w_add[SEG-1:0];
      end else begin : g_src
         assign w_a   = g_stg[k-1].g_rest.r_ra[SEG-1:0];
         assign w_b   = g_stg[k-1].g_rest.r_rb[SEG-1:0];
         assign w_ci  = g_stg[k-1].r_c;
         assign w_vi  = g_stg[k-1].r_v;
         assign w_sum = {w_add[SEG-1:0],
                         g_stg[k-1].r_sum};
      end

      assign w_add = {1'b0, w_a}
                   + {1'b0, w_b}
                   + {{SEG{1'b0}}, w_ci};

      // beat valid advances with the pipe, bubbles included
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_v <= 1'b0;
         end else if (w_adv) begin
            r_v <= w_vi;
         end
      end

      // sum-so-far and carry, loaded only for real beats
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_sum <= '0;
            r_c   <= 1'b0;
         end else if (w_adv && w_vi) begin
            r_sum <= w_sum;
            r_c   <= w_add[SEG];
         end
      end

      if (k < NSEG - 1) begin : g_rest
         logic [RW-1:0] w_na;
         logic [RW-1:0] w_nb;
         logic [RW-1:0] r_ra;
         logic [RW-1:0] r_rb;

         if (k == 0) begin : g_nxt
            assign w_na = io_bus.in_a[WIDTH-1:SEG];
            assign w_nb = w_bx[WIDTH-1:SEG];
         end else begin : g_nxt
            assign w_na =
               g_stg[k-1].g_rest.r_ra[RW+SEG-1:SEG];
            assign w_nb =
               g_stg[k-1].g_rest.r_rb[RW+SEG-1:SEG];
         end

         // skew: not-yet-added operand segments
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_ra <= '0;
               r_rb <= '0;
            end else if (w_adv && w_vi) begin
               r_ra <= w_na;
               r_rb <= w_nb;
            end
         end
      end

`ifdef OVERFLOW_FLAG_EN
      if (k == NSEG - 1) begin : g_ovf
         logic r_ovf;

         // top segment carries both operand MSBs
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_ovf <= 1'b0;
            end else if (w_adv && w_vi) begin
               r_ovf <= (w_a[SEG-1] == w_b[SEG-1])
                     && (w_add[SEG-1] != w_a[SEG-1]);
            end
         end
      end
`endif
   end

   assign io_bus.out_valid = w_out_valid;
   assign io_bus.out_sum   = g_stg[NSEG-1].r_sum;
   assign io_bus.out_cout  = g_stg[NSEG-1].r_c;
`ifdef OVERFLOW_FLAG_EN
   assign io_bus.out_ovf   = g_stg[NSEG-1].g_ovf.r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_adder_wrapper.sv
// Bench for pipelined_adder_wrapper: directed beats, stall, reset.
// Define OVERFLOW_FLAG_EN to also check out_ovf.
module tb_pipelined_adder_wrapper;
   localparam int WIDTH = 32;
   localparam int SEG   = 8;
   localparam int NSEG  = WIDTH / SEG;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_pass = 0;
   int   n_chk  = 0;
   int   n_out  = 0;
   logic saw_stall = 1'b0;
   logic [WIDTH+1:0] q[$];

   pipelined_adder_wrapper_if #(.WIDTH(WIDTH)) bus ();

   pipelined_adder_wrapper #(
      .WIDTH(WIDTH),
      .SEG  (SEG)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .io_bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h",
                    nm, got, exp);
   endtask

   // {ovf, cout, sum} from integer arithmetic
   function automatic logic [WIDTH+1:0] model(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic cin,
      input logic sub);
      longint ua, ub, sa, sb, u, s, lim;
      logic [63:0] uv;
      logic ovf;
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lim = longint'(1) << (WIDTH - 1);
      if (sub) begin
         u = ua - ub + (longint'(1) << WIDTH);
         s = sa - sb;
      end else begin
         u = ua + ub + longint'(cin);
         s = sa + sb + longint'(cin);
      end
      uv  = u;
      ovf = (s >= lim) || (s < -lim);
      return {ovf, uv[WIDTH], uv[WIDTH-1:0]};
   endfunction

   // scoreboard and per-cycle output check
   always @(negedge clk) begin
      if (!rst) begin
         q.delete();
      end else begin
         chk("in_ready_rule", bus.in_ready,
             bus.out_ready || !bus.out_valid);
         if (bus.out_valid && !bus.in_ready)
            saw_stall = 1'b1;
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               chk("stale_beat", bus.out_valid, 1'b0);
            end else begin
               chk("sum", bus.out_sum, q[0][WIDTH-1:0]);
               chk("cout", bus.out_cout, q[0][WIDTH]);
`ifdef OVERFLOW_FLAG_EN
               chk("ovf", bus.out_ovf, q[0][WIDTH+1]);
`endif
               if (bus.out_ready) begin
                  void'(q.pop_front());
                  n_out++;
               end
            end
         end
         if (bus.in_valid && bus.in_ready)
            q.push_back(model(bus.in_a, bus.in_b,
                              bus.in_cin, bus.in_sub));
      end
   end

   task automatic drive(input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b,
                        input logic cin,
                        input logic sub);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_sub   = sub;
   endtask

   task automatic run_one(input string nm,
                          input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b,
                          input logic cin,
                          input logic sub,
                          input logic [WIDTH-1:0] es,
                          input logic ec,
                          input logic eo);
      int lat;
      drive(a, b, cin, sub);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 4 * NSEG) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_lat"}, lat, NSEG);
      chk({nm, "_sum"}, bus.out_sum, es);
      chk({nm, "_cout"}, bus.out_cout, ec);
`ifdef OVERFLOW_FLAG_EN
      chk({nm, "_ovf"}, bus.out_ovf, eo);
`else
      if (eo === 1'bx) $display("note: ovf x");
`endif
      @(posedge clk); #1;
   endtask

   task automatic stream8();
      logic [WIDTH-1:0] va[8];
      logic [WIDTH-1:0] vb[8];
      logic [7:0] vc;
      logic [7:0] vs;
      int idx, cyc, base;
      logic acc;
      va = '{32'h0000_0001, 32'hFFFF_FFFF,
             32'h1234_5678, 32'h8000_0000,
             32'h0000_00FF, 32'h7FFF_FFFF,
             32'hDEAD_BEEF, 32'h0000_0000};
      vb = '{32'h0000_0002, 32'h0000_0001,
             32'h1111_1111, 32'h8000_0000,
             32'h0000_FF01, 32'h7FFF_FFFF,
             32'h0BAD_F00D, 32'h0000_0001};
      vc = 8'b1010_0110;
      vs = 8'b1100_1010;
      idx  = 0;
      cyc  = 0;
      base = n_out;
      saw_stall = 1'b0;
      while ((idx < 8 || n_out < base + 8)
             && cyc < 200) begin
         bus.out_ready = !(cyc >= 3 && cyc < 8);
         if (idx < 8) drive(va[idx], vb[idx],
                            vc[idx], vs[idx]);
         else bus.in_valid = 1'b0;
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("stream_timeout", cyc < 200, 1'b1);
      chk("stream_count", n_out - base, 8);
      chk("stream_stall_seen", saw_stall, 1'b1);
      chk("stream_drained", q.size(), 0);
   endtask

   task automatic reset_mid();
      int guard, base;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(32'h11 + i, 32'h22, 1'b0, 1'b0);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      guard = 0;
      while (!bus.out_valid && guard < 4 * NSEG) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("rst_pre_valid", bus.out_valid, 1'b1);
      chk("rst_pre_sum", bus.out_sum, 32'h33);
      rst = 1'b0;
      #1;
      chk("rst_async_valid", bus.out_valid, 1'b0);
      chk("rst_async_sum", bus.out_sum, 32'h0);
      chk("rst_async_cout", bus.out_cout, 1'b0);
`ifdef OVERFLOW_FLAG_EN
      chk("rst_async_ovf", bus.out_ovf, 1'b0);
`endif
      @(posedge clk); #1;
      rst = 1'b1;
      bus.out_ready = 1'b1;
      base = n_out;
      @(posedge clk); #1;
      chk("rst_in_ready", bus.in_ready, 1'b1);
      repeat (2 * NSEG) @(posedge clk);
      #1;
      chk("rst_no_stale", n_out - base, 0);
      chk("rst_out_idle", bus.out_valid, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit hit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", bus.out_valid, 1'b0);
      chk("reset_sum", bus.out_sum, 32'h0);
      chk("reset_cout", bus.out_cout, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("release_in_ready", bus.in_ready, 1'b1);

      run_one("seg_carry", 32'h0000_00FF, 32'h1,
              1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
      run_one("ripple", 32'hFFFF_FFFF, 32'h0,
              1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run_one("sub_neg", 32'h5, 32'h7,
              1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_one("sub_pos", 32'h7, 32'h5,
              1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
      run_one("ovf_add", 32'h7FFF_FFFF, 32'h1,
              1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      run_one("ovf_sub", 32'h8000_0000, 32'h1,
              1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

      stream8();
      reset_mid();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
